counter_74161_744040_dff: RTL and testbench
===========================================

COUNTER_74161_744040_DFF -- requirements
Module: counter_74161_744040_dff

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge only.
REQ-003 n_rst  in  1  reset, synchronous and active-low; clears all three sections.
REQ-004 clr_n  in  1  4-bit counter clear, synchronous, active-low.
REQ-005 load_n  in  1  4-bit counter parallel load, synchronous, active-low.
REQ-006 enp  in  1  4-bit counter count enable P.
REQ-007 ent  in  1  4-bit counter count enable T; also gates rco.
REQ-008 p  in  4  4-bit counter load value.
REQ-009 q  out  4  4-bit counter state.
REQ-010 rco  out  1  4-bit counter ripple carry out.
REQ-011 clr  in  1  12-bit counter clear, synchronous, active-high.
REQ-012 cnt_en  in  1  12-bit counter increment enable; replaces the part's falling-edge clock.
REQ-013 cq  out  12  12-bit counter state.
REQ-014 d  in  1  flip-flop data.
REQ-015 n_sd  in  1  flip-flop set, synchronous, active-low.
REQ-016 n_cd  in  1  flip-flop clear, synchronous, active-low.
REQ-017 ff_q  out  1  flip-flop true output.
REQ-018 ff_n_q  out  1  flip-flop complement output.

Function
4-bit counter, 74161 behaviour, all controls synchronous:
REQ-019 The counter SHALL apply this priority at each edge: n_rst=0 or clr_n=0, then q=0.
REQ-020 Otherwise, with load_n=0, the counter SHALL set q=p, regardless of enp and ent.
REQ-021 Otherwise, with enp=1 and ent=1, the counter SHALL set q=q+1 mod 16, wrapping 15 to 0.
REQ-022 Otherwise the counter SHALL hold q.
REQ-023 rco SHALL be combinational, equal to ent AND (q==15), and independent of enp.

12-bit counter, 74HC4040 behaviour:
REQ-024 The counter SHALL apply this priority at each edge: n_rst=0 or clr=1, then cq=0.
REQ-025 Otherwise, with cnt_en=1, the counter SHALL set cq=cq+1 mod 4096, wrapping 4095 to 0.
REQ-026 Otherwise the counter SHALL hold cq.
REQ-027 The counter SHALL advance at most one count per clk edge, with no intermediate ripple states visible on cq.

D flip-flop, 7474 behaviour, synchronous:
REQ-028 The flip-flop SHALL apply this priority at each edge: n_rst=0, then ff_q=0 and ff_n_q=1.
REQ-029 Otherwise, with n_sd=0 and n_cd=0, the flip-flop SHALL set ff_q=1 and ff_n_q=1, matching the part's both-high state.
REQ-030 Otherwise, with n_cd=0, the flip-flop SHALL set ff_q=0 and ff_n_q=1.
REQ-031 Otherwise, with n_sd=0, the flip-flop SHALL set ff_q=1 and ff_n_q=0.
REQ-032 Otherwise the flip-flop SHALL set ff_q=d and ff_n_q=~d.
REQ-033 Both outputs SHALL be registered, and ff_n_q SHALL equal ~ff_q except in the REQ-029 case.
REQ-034 When n_sd or n_cd is released, the outputs SHALL take the d-captured value at the next edge.

General:
REQ-035 The three sections SHALL be independent apart from the shared clk and n_rst.
REQ-036 The design SHALL contain no latches, asynchronous paths or gated clocks.
REQ-037 Register outputs SHALL change only after a rising clk edge.

Reset
REQ-038 While n_rst=0 at an edge, after that edge the outputs SHALL be q=0, cq=0, ff_q=0, ff_n_q=1; rco then equals 0 because q=0.
REQ-039 Reset SHALL override every other control in the same cycle, including a concurrent load, count, set or clear.
REQ-040 Asserting reset mid-count SHALL discard the state at the next edge.
REQ-041 Before the first edge with n_rst=0, outputs SHALL be undefined.
REQ-042 After n_rst returns to 1, normal operation SHALL resume on the first edge.

Verification
REQ-043 4-bit wrap: reset, then enp=ent=1 for 16 edges -> q steps 1..15,0; rco=1 only while q=15.
REQ-044 4-bit load and rco gating: load_n=0, p=0xA, enp=ent=1 -> q=0xA. Then with q=15: ent=0 -> rco=0; enp=0, ent=1 -> rco=1 and q holds.
REQ-045 12-bit wrap and clear: cnt_en=1 for 4096 edges from 0 -> cq returns to 0. clr=1 while cnt_en=1 -> cq=0 at next edge.
REQ-046 Flip-flop: d=1 -> ff_q=1, ff_n_q=0. n_cd=0 -> ff_q=0. n_sd=0 with n_cd=0 -> both outputs 1. Release both with d=0 -> ff_q=0, ff_n_q=1.
REQ-047 Mid-operation reset: q=7, cq=0x123, ff_q=1, then n_rst=0 for one edge with load_n=0, cnt_en=1 and n_sd=0 active -> q=0, cq=0, ff_q=0, ff_n_q=1.
REQ-048 Synchronous check: toggle clr_n, clr and n_cd between edges only -> no output change until the next rising edge.

Source files
------------

// File: rtl/counter_74161_744040_dff.sv
// Three independent sections on one clock: a 74161-style 4-bit counter, a
// 74HC4040-style 12-bit counter and a 7474-style D flip-flop, all synchronous.
module counter_74161_744040_dff (
  input  logic        clk,
  input  logic        n_rst,
  // 4-bit counter
  input  logic        clr_n,
  input  logic        load_n,
  input  logic        enp,
  input  logic        ent,
  input  logic [3:0]  p,
  output logic [3:0]  q,
  output logic        rco,
  // 12-bit counter
  input  logic        clr,
  input  logic        cnt_en,
  output logic [11:0] cq,
  // D flip-flop
  input  logic        d,
  input  logic        n_sd,
  input  logic        n_cd,
  output logic        ff_q,
  output logic        ff_n_q
);

  // NOTE: state registers use non-blocking assignments so every section
  // samples its inputs at the same edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!n_rst || !clr_n) begin
      q <= 4'h0;
    end else if (!load_n) begin
      q <= p;
    end else if (enp && ent) begin
      q <= q + 4'h1;
    end
  end

  // Carry looks only at ent, so cascaded stages can freeze higher digits via enp.
  assign rco = ent && (q == 4'hF);

  // The original part rippled on a falling clock; here one synchronous adder
  // advances the whole word at once, so no intermediate values appear on cq.
  always_ff @(posedge clk) begin
    if (!n_rst || clr) begin
      cq <= 12'h000;
    end else if (cnt_en) begin
      cq <= cq + 12'h001;
    end
  end

  // Set and clear together drive both outputs high, as the real part does.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ff_q   <= 1'b0;
      ff_n_q <= 1'b1;
    end else if (!n_sd && !n_cd) begin
      ff_q   <= 1'b1;
      ff_n_q <= 1'b1;
    end else if (!n_cd) begin
      ff_q   <= 1'b0;
      ff_n_q <= 1'b1;
    end else if (!n_sd) begin
      ff_q   <= 1'b1;
      ff_n_q <= 1'b0;
    end else begin
      ff_q   <= d;
      ff_n_q <= ~d;
    end
  end

endmodule

// File: tb/tb_counter_74161_744040_dff.sv
// Directed bench for counter_74161_744040_dff: reset, 4-bit count/load/carry,
// 12-bit wrap/clear, flip-flop set/clear and synchronous-only behaviour.
module tb_counter_74161_744040_dff;

  logic        clk = 1'b0;
  logic        n_rst, clr_n, load_n, enp, ent;
  logic [3:0]  p, q;
  logic        rco;
  logic        clr, cnt_en;
  logic [11:0] cq;
  logic        d, n_sd, n_cd, ff_q, ff_n_q;

  int n_checks = 0;
  int n_fail   = 0;

  counter_74161_744040_dff dut (
    .clk(clk), .n_rst(n_rst),
    .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent), .p(p), .q(q), .rco(rco),
    .clr(clr), .cnt_en(cnt_en), .cq(cq),
    .d(d), .n_sd(n_sd), .n_cd(n_cd), .ff_q(ff_q), .ff_n_q(ff_n_q)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    n_rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; p = 4'h0;
    clr = 1'b0; cnt_en = 1'b0;
    d = 1'b0; n_sd = 1'b1; n_cd = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    n_rst = 1'b0; load_n = 1'b0; p = 4'h9; enp = 1'b1; ent = 1'b1;
    cnt_en = 1'b1; n_sd = 1'b0; d = 1'b1;
    tick();
    n_checks++; if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %0h want 0", q); end
    n_checks++; if (cq !== 12'h000) begin n_fail++; $display("FAIL reset_cq: got %0h want 0", cq); end
    n_checks++; if (ff_q !== 1'b0 || ff_n_q !== 1'b1) begin
      n_fail++; $display("FAIL reset_ff: got q=%b nq=%b want q=0 nq=1", ff_q, ff_n_q); end
    n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL reset_rco: got %b want 0", rco); end
    idle();
  endtask

  task automatic test_4bit_wrap();
    logic [3:0] exp_q;
    idle();
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_q = 4'(i);
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL wrap_q step %0d: got %0h want %0h", i, q, exp_q); end
      n_checks++; if (rco !== (exp_q == 4'hF)) begin
        n_fail++; $display("FAIL wrap_rco step %0d: got %b want %b", i, rco, exp_q == 4'hF); end
    end
    n_checks++; if (cq !== 12'h000) begin n_fail++; $display("FAIL wrap_cq_independent: got %0h want 0", cq); end
    idle();
  endtask

  task automatic test_4bit_load_rco();
    idle();
    load_n = 1'b0; p = 4'hA; enp = 1'b1; ent = 1'b1;
    tick();
    n_checks++; if (q !== 4'hA) begin n_fail++; $display("FAIL load_a: got %0h want a", q); end
    p = 4'hF;
    tick();
    n_checks++; if (q !== 4'hF) begin n_fail++; $display("FAIL load_f: got %0h want f", q); end
    load_n = 1'b1; enp = 1'b1; ent = 1'b0;
    #1;
    n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL rco_ent0: got %b want 0", rco); end
    tick();
    n_checks++; if (q !== 4'hF) begin n_fail++; $display("FAIL hold_ent0: got %0h want f", q); end
    enp = 1'b0; ent = 1'b1;
    #1;
    n_checks++; if (rco !== 1'b1) begin n_fail++; $display("FAIL rco_enp0: got %b want 1", rco); end
    tick();
    n_checks++; if (q !== 4'hF) begin n_fail++; $display("FAIL hold_enp0: got %0h want f", q); end
    clr_n = 1'b0; load_n = 1'b0; p = 4'h6; enp = 1'b1;
    tick();
    n_checks++; if (q !== 4'h0) begin n_fail++; $display("FAIL clr_over_load: got %0h want 0", q); end
    idle();
  endtask

  task automatic test_12bit();
    idle();
    clr = 1'b1; tick(); clr = 1'b0;
    cnt_en = 1'b1;
    for (int i = 1; i <= 4095; i++) begin
      tick();
      if (i == 1 || i == 256 || i == 4095) begin
        n_checks++; if (cq !== 12'(i)) begin n_fail++; $display("FAIL cq_count %0d: got %0h want %0h", i, cq, 12'(i)); end
      end
    end
    tick();
    n_checks++; if (cq !== 12'h000) begin n_fail++; $display("FAIL cq_wrap: got %0h want 0", cq); end
    tick(); tick(); tick();
    cnt_en = 1'b0;
    tick();
    n_checks++; if (cq !== 12'h003) begin n_fail++; $display("FAIL cq_hold: got %0h want 3", cq); end
    cnt_en = 1'b1; clr = 1'b1;
    tick();
    n_checks++; if (cq !== 12'h000) begin n_fail++; $display("FAIL cq_clr: got %0h want 0", cq); end
    idle();
  endtask

  task automatic test_ff();
    idle();
    d = 1'b1; tick();
    n_checks++; if (ff_q !== 1'b1 || ff_n_q !== 1'b0) begin
      n_fail++; $display("FAIL ff_d1: got q=%b nq=%b want q=1 nq=0", ff_q, ff_n_q); end
    n_cd = 1'b0; tick();
    n_checks++; if (ff_q !== 1'b0 || ff_n_q !== 1'b1) begin
      n_fail++; $display("FAIL ff_clear: got q=%b nq=%b want q=0 nq=1", ff_q, ff_n_q); end
    n_sd = 1'b0; tick();
    n_checks++; if (ff_q !== 1'b1 || ff_n_q !== 1'b1) begin
      n_fail++; $display("FAIL ff_both: got q=%b nq=%b want q=1 nq=1", ff_q, ff_n_q); end
    n_cd = 1'b1; d = 1'b0; tick();
    n_checks++; if (ff_q !== 1'b1 || ff_n_q !== 1'b0) begin
      n_fail++; $display("FAIL ff_set: got q=%b nq=%b want q=1 nq=0", ff_q, ff_n_q); end
    n_sd = 1'b1; tick();
    n_checks++; if (ff_q !== 1'b0 || ff_n_q !== 1'b1) begin
      n_fail++; $display("FAIL ff_release_d0: got q=%b nq=%b want q=0 nq=1", ff_q, ff_n_q); end
    idle();
  endtask

  task automatic test_mid_reset();
    idle();
    load_n = 1'b0; p = 4'h7; clr = 1'b1; d = 1'b1;
    tick();
    load_n = 1'b1; clr = 1'b0; cnt_en = 1'b1;
    for (int i = 0; i < 12'h123; i++) tick();
    cnt_en = 1'b0;
    n_checks++; if (q !== 4'h7 || cq !== 12'h123 || ff_q !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got q=%0h cq=%0h ff=%b want 7 123 1", q, cq, ff_q); end
    n_rst = 1'b0; load_n = 1'b0; p = 4'h5; enp = 1'b1; ent = 1'b1; cnt_en = 1'b1; n_sd = 1'b0;
    tick();
    n_checks++; if (q !== 4'h0 || cq !== 12'h000 || ff_q !== 1'b0 || ff_n_q !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got q=%0h cq=%0h ff=%b nff=%b want 0 0 0 1", q, cq, ff_q, ff_n_q); end
    n_rst = 1'b1; load_n = 1'b1; n_sd = 1'b1; d = 1'b1;
    tick();
    n_checks++; if (q !== 4'h1 || cq !== 12'h001 || ff_q !== 1'b1) begin
      n_fail++; $display("FAIL mid_resume: got q=%0h cq=%0h ff=%b want 1 1 1", q, cq, ff_q); end
    idle();
  endtask

  task automatic test_sync();
    idle();
    load_n = 1'b0; p = 4'h5; d = 1'b1; cnt_en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    load_n = 1'b1; cnt_en = 1'b0;
    #2;
    clr_n = 1'b0; clr = 1'b1; n_cd = 1'b0;
    #2;
    n_checks++; if (q !== 4'h5 || cq !== 12'h001 || ff_q !== 1'b1) begin
      n_fail++; $display("FAIL sync_no_change: got q=%0h cq=%0h ff=%b want 5 1 1", q, cq, ff_q); end
    tick();
    n_checks++; if (q !== 4'h0 || cq !== 12'h000 || ff_q !== 1'b0) begin
      n_fail++; $display("FAIL sync_applied: got q=%0h cq=%0h ff=%b want 0 0 0", q, cq, ff_q); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_4bit_wrap();
    test_4bit_load_rco();
    test_12bit();
    test_ff();
    test_mid_reset();
    test_sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
